imem_uart_loader: RTL and testbench

- Sequences UART programming of the 20-word instruction memory.
- Takes the byte stream from the UART receiver, frames it, and assembles little-endian 32-bit words.
- Drives the memory's write enable, address and write-data inputs, and muxes the memory address between loader and core PC.
- Holds the core in reset while a load is in progress or after a failed load.

---
 rtl/imem_uart_loader.sv | 166 ++++++++++++++++
 tb/tb_imem_uart_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_uart_loader.sv
// UART programming sequencer for the instruction memory.
// Frames the received byte stream (sync, count, data, checksum), packs
// little-endian 32-bit words, issues one memory write per word and keeps
// the core in reset while a load is running or after a failed load.
module imem_uart_loader #(
  parameter int         MEM_WORDS      = 20,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic [31:0] pc,
  output logic        imem_we,
  output logic [31:0] imem_a,
  output logic [31:0] imem_wd,
  output logic        core_hold,
  output logic        busy,
  output logic        load_done,
  output logic        load_err
);

  localparam int                 IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int                 TMR_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]         MAX_COUNT = 8'(MEM_WORDS);
  localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   word_idx_q;
  logic [1:0]         byte_idx_q;
  logic [7:0]         count_q;
  logic [7:0]         csum_q;
  logic [23:0]        buffer_q;   // lower three bytes; the fourth goes straight into the word
  logic [31:0]        word_q;
  logic               skid_v_q;
  logic [7:0]         skid_q;
  logic [TMR_W-1:0]   timer_q;
  logic               core_hold_q;
  logic               load_err_q;

  logic               byte_v;
  logic [7:0]         byte_d;
  logic               timed_out;
  logic               last_word;

  // Byte source: a byte parked in the skid register during WRITE takes priority.
  assign byte_v    = skid_v_q | rx_valid;
  assign byte_d    = skid_v_q ? skid_q : rx_data;
  assign timed_out = !byte_v && (timer_q == TMR_LAST);
  assign last_word = (8'(word_idx_q) == (count_q - 8'd1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and output decode.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    imem_we   = 1'b0;
    load_done = 1'b0;
    busy      = (state_q != S_IDLE);
    imem_a    = pc;
    if (state_q != S_IDLE) imem_a = {{(30 - IDX_W){1'b0}}, word_idx_q, 2'b00};
    case (state_q)
      S_IDLE:  if (rx_valid && rx_data == SYNC_BYTE) state_d = S_COUNT;
      S_COUNT: begin
        if (byte_v) state_d = (byte_d == 8'd0 || byte_d > MAX_COUNT) ? S_ERR : S_DATA;
        else if (timed_out) state_d = S_ERR;
      end
      S_DATA: begin
        if (byte_v) begin
          if (byte_idx_q == 2'd3) state_d = S_WRITE;
        end else if (timed_out) begin
          state_d = S_ERR;
        end
      end
      S_WRITE: begin
        imem_we = 1'b1;
        state_d = last_word ? S_CHECK : S_DATA;
      end
      S_CHECK: begin
        if (byte_v) state_d = (byte_d == csum_q) ? S_DONE : S_ERR;
        else if (timed_out) state_d = S_ERR;
      end
      S_DONE: begin
        load_done = 1'b1;
        state_d   = S_IDLE;
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: framing counters, word assembly, checksum, skid, timer and status flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      count_q     <= '0;
      csum_q      <= '0;
      buffer_q    <= '0;
      word_q      <= '0;
      skid_v_q    <= 1'b0;
      skid_q      <= '0;
      timer_q     <= '0;
      core_hold_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      skid_v_q <= (state_q == S_WRITE) && rx_valid;
      if (state_q == S_WRITE) skid_q <= rx_data;

      if (state_q == S_COUNT || state_q == S_DATA || state_q == S_WRITE || state_q == S_CHECK)
        timer_q <= byte_v ? '0 : timer_q + TMR_W'(1);
      else
        timer_q <= '0;

      case (state_q)
        S_IDLE: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            core_hold_q <= 1'b1;
            load_err_q  <= 1'b0;
          end
        end
        S_COUNT: begin
          if (state_d == S_DATA) begin
            count_q    <= byte_d;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            csum_q     <= '0;
          end
        end
        S_DATA: begin
          if (byte_v) begin
            csum_q     <= csum_q ^ byte_d;
            byte_idx_q <= byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0:    buffer_q[7:0]   <= byte_d;
              2'd1:    buffer_q[15:8]  <= byte_d;
              2'd2:    buffer_q[23:16] <= byte_d;
              default: word_q          <= {byte_d, buffer_q};
            endcase
          end
        end
        S_WRITE: if (!last_word) word_idx_q <= word_idx_q + IDX_W'(1);
        S_DONE:  core_hold_q <= 1'b0;
        default: ;
      endcase

      if (state_d == S_ERR) load_err_q <= 1'b1;
    end
  end

  assign imem_wd   = word_q;
  assign core_hold = core_hold_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: valid and failing frames, count
// bounds, skid capture on a full 20-word load, timeout and mid-frame reset.
module tb_imem_uart_loader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [31:0] pc;
  logic        imem_we;
  logic [31:0] imem_a;
  logic [31:0] imem_wd;
  logic        core_hold;
  logic        busy;
  logic        load_done;
  logic        load_err;

  int          n_checks = 0;
  int          n_errors = 0;
  int          wr_cnt   = 0;
  int          done_cnt = 0;
  logic [31:0] wr_a [0:255];
  logic [31:0] wr_d [0:255];

  imem_uart_loader #(.TIMEOUT_CYCLES(16)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .pc        (pc),
    .imem_we   (imem_we),
    .imem_a    (imem_a),
    .imem_wd   (imem_wd),
    .core_hold (core_hold),
    .busy      (busy),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 CLK = ~CLK;

  // Log every memory write and every load_done pulse, sampled mid-cycle.
  always @(negedge CLK) begin
    if (imem_we && wr_cnt < 256) begin
      wr_a[wr_cnt] = imem_a;
      wr_d[wr_cnt] = imem_wd;
      wr_cnt++;
    end
    if (load_done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one byte for one cycle, then idle cycles; always returns 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int idle);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge CLK); #1;
    rx_valid = 1'b0;
    for (int i = 0; i < idle; i++) begin
      @(posedge CLK); #1;
    end
  endtask

  // Count and data bytes of the two-word program; the checksum byte is sent back to back.
  task automatic send_body(input logic [7:0] cs);
    logic [7:0] body [0:8];
    body = '{8'h02, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    for (int i = 0; i < 9; i++) send_byte(body[i], 1);
    send_byte(cs, 0);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    int          wbase;
    int          dbase;
    logic [7:0]  csum;
    logic [31:0] w;
    logic [31:0] exp_w [0:19];

    RST      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    pc       = 32'h0000_1234;
    #12;
    check("rst_we",        {31'd0, imem_we},   32'd0);
    check("rst_wd",        imem_wd,            32'd0);
    check("rst_hold",      {31'd0, core_hold}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_done",      {31'd0, load_done}, 32'd0);
    check("rst_err",       {31'd0, load_err},  32'd0);
    check("rst_a_is_pc",   imem_a,             32'h0000_1234);
    @(posedge CLK); #1;
    RST = 1'b0;
    pc  = 32'h0000_0040;
    step(2);

    // Valid two-word load. XOR of 13 00 50 00 93 00 10 00 is 0xC0.
    wbase = wr_cnt; dbase = done_cnt;
    send_byte(8'hA5, 1);
    send_body(8'hC0);
    check("t1_done_pulse", {31'd0, load_done}, 32'd1);
    check("t1_hold_in_done", {31'd0, core_hold}, 32'd1);
    step(1);
    check("t1_done_low",   {31'd0, load_done}, 32'd0);
    check("t1_hold_rel",   {31'd0, core_hold}, 32'd0);
    check("t1_busy",       {31'd0, busy},      32'd0);
    check("t1_err",        {31'd0, load_err},  32'd0);
    check("t1_a_is_pc",    imem_a,             32'h0000_0040);
    check("t1_nwrites",    32'(wr_cnt - wbase),   32'd2);
    check("t1_a0",         wr_a[wbase],        32'h0000_0000);
    check("t1_d0",         wr_d[wbase],        32'h0050_0013);
    check("t1_a1",         wr_a[wbase+1],      32'h0000_0004);
    check("t1_d1",         wr_d[wbase+1],      32'h0010_0093);
    check("t1_ndone",      32'(done_cnt - dbase), 32'd1);
    check("t1_wd_held",    imem_wd,            32'h0010_0093);

    // Bad checksum: words still written, error sticks, core stays held.
    wbase = wr_cnt; dbase = done_cnt;
    send_byte(8'hA5, 1);
    send_body(8'h00);
    check("t2_err",        {31'd0, load_err},  32'd1);
    step(1);
    check("t2_busy",       {31'd0, busy},      32'd0);
    check("t2_hold",       {31'd0, core_hold}, 32'd1);
    check("t2_err_held",   {31'd0, load_err},  32'd1);
    check("t2_nwrites",    32'(wr_cnt - wbase),   32'd2);
    check("t2_ndone",      32'(done_cnt - dbase), 32'd0);
    dbase = done_cnt;
    send_byte(8'hA5, 0);
    check("t2_err_clr",    {31'd0, load_err},  32'd0);
    check("t2_busy_cnt",   {31'd0, busy},      32'd1);
    step(1);
    send_body(8'hC0);
    step(2);
    check("t2_rel_hold",   {31'd0, core_hold}, 32'd0);
    check("t2_rel_err",    {31'd0, load_err},  32'd0);
    check("t2_rel_done",   32'(done_cnt - dbase), 32'd1);

    // Word count out of range on both sides.
    wbase = wr_cnt;
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    check("t3_n0_err",     {31'd0, load_err},  32'd1);
    check("t3_n0_hold",    {31'd0, core_hold}, 32'd1);
    step(1);
    send_byte(8'hA5, 0);
    check("t3_sync_clr",   {31'd0, load_err},  32'd0);
    send_byte(8'h15, 0);
    check("t3_n21_err",    {31'd0, load_err},  32'd1);
    step(1);
    check("t3_busy",       {31'd0, busy},      32'd0);
    check("t3_hold",       {31'd0, core_hold}, 32'd1);
    check("t3_nwrites",    32'(wr_cnt - wbase), 32'd0);

    // Full 20-word load; the byte after each word lands in the WRITE cycle.
    wbase = wr_cnt; dbase = done_cnt;
    csum  = 8'h00;
    send_byte(8'hA5, 1);
    send_byte(8'd20, 1);
    for (int k = 0; k < 20; k++) begin
      w        = {8'hA5, 8'(k), 8'(k * 3), ~8'(k)};
      exp_w[k] = w;
      for (int j = 0; j < 4; j++) begin
        csum ^= w[8*j +: 8];
        send_byte(w[8*j +: 8], (j == 3) ? 0 : 1);
      end
    end
    send_byte(csum, 0);
    step(3);
    check("t4_nwrites",    32'(wr_cnt - wbase),   32'd20);
    check("t4_ndone",      32'(done_cnt - dbase), 32'd1);
    check("t4_err",        {31'd0, load_err},  32'd0);
    check("t4_hold",       {31'd0, core_hold}, 32'd0);
    for (int k = 0; k < 20; k++) begin
      check($sformatf("t4_a%0d", k), wr_a[wbase+k], 32'(k * 4));
      check($sformatf("t4_d%0d", k), wr_d[wbase+k], exp_w[k]);
    end

    // Timeout: 15 idle cycles keep the frame alive, the 16th aborts it.
    wbase = wr_cnt;
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h11, 0);
    step(15);
    check("t5_alive_busy", {31'd0, busy},      32'd1);
    check("t5_alive_err",  {31'd0, load_err},  32'd0);
    step(1);
    check("t5_to_err",     {31'd0, load_err},  32'd1);
    check("t5_to_hold",    {31'd0, core_hold}, 32'd1);
    check("t5_nwrites",    32'(wr_cnt - wbase), 32'd0);

    // Asynchronous reset in the middle of a frame.
    step(2);
    send_byte(8'hA5, 1);
    send_byte(8'h02, 1);
    send_byte(8'h13, 1);
    send_byte(8'h00, 1);
    send_byte(8'h50, 0);
    #2 RST = 1'b1;
    #1;
    check("t6_busy",       {31'd0, busy},      32'd0);
    check("t6_hold",       {31'd0, core_hold}, 32'd0);
    check("t6_err",        {31'd0, load_err},  32'd0);
    check("t6_we",         {31'd0, imem_we},   32'd0);
    check("t6_wd",         imem_wd,            32'd0);
    check("t6_a_is_pc",    imem_a,             32'h0000_0040);
    @(posedge CLK); #1;
    RST = 1'b0;
    send_byte(8'h00, 1);
    check("t6_no_resync",  {31'd0, busy},      32'd0);
    wbase = wr_cnt; dbase = done_cnt;
    send_byte(8'hA5, 1);
    send_body(8'hC0);
    step(2);
    check("t6_nwrites",    32'(wr_cnt - wbase),   32'd2);
    check("t6_d0",         wr_d[wbase],        32'h0050_0013);
    check("t6_d1",         wr_d[wbase+1],      32'h0010_0093);
    check("t6_ndone",      32'(done_cnt - dbase), 32'd1);
    check("t6_hold_rel",   {31'd0, core_hold}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
